rope_solver_ctrl: RTL and testbench

Sequencer and distance-constraint solver for the rope/chain simulation. Each frame it broadcasts one Verlet integration pulse to every node, then reads back all node positions. It computes per-link clamp corrections in Q12.20 fixed point and writes them to the nodes through their fix-constraint inputs, one node at a time, for a fixed number of relaxation iterations. It is the consumer/driver at the other end of the node position and fix-constraint interface.

---
 rtl/rope_solver_ctrl.sv | 161 ++++++++++++++++
 tb/tb_rope_solver_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rope_solver_ctrl.sv
// rtl/rope_solver_ctrl.sv - frame sequencer and per-link distance clamp solver for the rope chain
// Optional head pinning via ROPE_PIN_EN (PIN state and anchor writes present only when defined).
module rope_solver_ctrl #(
    parameter int          NODES = 8,
    parameter int          ITER  = 4,
    parameter logic [31:0] REST  = 32'h00A00000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           anchor_x,
    input  logic [31:0]           anchor_y,
    input  logic [32*NODES-1:0]   x_pos_all,
    input  logic [32*NODES-1:0]   y_pos_all,
    output logic                  verlet_state,
    output logic [NODES-1:0]      fix_en,
    output logic [31:0]           x_fix_constraint,
    output logic [31:0]           y_fix_constraint,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           clamp_cnt
);
    localparam int KW = $clog2(NODES);
    localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_VERLET, S_SETTLE, S_PIN, S_CALC, S_WRITE, S_DONE
    } state_t;

    state_t             state_q;
    logic [KW-1:0]      k_q;
    logic [IW-1:0]      it_q;
    logic               verlet_q;
    logic [NODES-1:0]   fix_en_q;
    logic [31:0]        x_fix_q;
    logic [31:0]        y_fix_q;
    logic               busy_q;
    logic               done_q;
    logic [15:0]        clamp_cnt_q;

    logic [31:0]        xs [NODES];
    logic [31:0]        ys [NODES];
    logic [31:0]        x_corr_d;
    logic [31:0]        y_corr_d;
    logic               hit_x_d;
    logic               hit_y_d;

`ifndef ROPE_PIN_EN
    logic unused_anchor;
    assign unused_anchor = ^{anchor_x, anchor_y};
`endif

    // Difference taken in 33 bits so far-apart nodes never wrap to the wrong sign.
    function automatic logic [31:0] clamp_axis(input logic [31:0] prev, input logic [31:0] cur,
                                               output logic hit);
        logic signed [32:0] d;
        logic signed [32:0] lim;
        d   = $signed({cur[31], cur}) - $signed({prev[31], prev});
        lim = $signed({1'b0, REST});
        hit = 1'b0;
        clamp_axis = cur;
        if (d > lim) begin
            clamp_axis = prev + REST;
            hit = 1'b1;
        end else if (d < -lim) begin
            clamp_axis = prev - REST;
            hit = 1'b1;
        end
    endfunction

    always_comb begin
        for (int i = 0; i < NODES; i++) begin
            xs[i] = x_pos_all[32*i +: 32];
            ys[i] = y_pos_all[32*i +: 32];
        end
        x_corr_d = clamp_axis(xs[k_q - KW'(1)], xs[k_q], hit_x_d);
        y_corr_d = clamp_axis(ys[k_q - KW'(1)], ys[k_q], hit_y_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            k_q         <= KW'(1);
            it_q        <= '0;
            verlet_q    <= 1'b0;
            fix_en_q    <= '0;
            x_fix_q     <= '0;
            y_fix_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            clamp_cnt_q <= '0;
        end else begin
            verlet_q <= 1'b0;
            fix_en_q <= '0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    state_q     <= S_VERLET;
                    verlet_q    <= 1'b1;
                    busy_q      <= 1'b1;
                    clamp_cnt_q <= '0;
                    it_q        <= '0;
                end
                S_VERLET: state_q <= S_SETTLE;
                S_SETTLE: begin
                    k_q <= KW'(1);
`ifdef ROPE_PIN_EN
                    state_q  <= S_PIN;
                    fix_en_q <= NODES'(1);
                    x_fix_q  <= anchor_x;
                    y_fix_q  <= anchor_y;
`else
                    state_q  <= S_CALC;
`endif
                end
                S_PIN: state_q <= S_CALC;
                S_CALC: begin
                    state_q  <= S_WRITE;
                    fix_en_q <= NODES'(1) << k_q;
                    x_fix_q  <= x_corr_d;
                    y_fix_q  <= y_corr_d;
                    if ((hit_x_d || hit_y_d) && clamp_cnt_q != 16'hFFFF)
                        clamp_cnt_q <= clamp_cnt_q + 16'd1;
                end
                S_WRITE: begin
                    if (k_q < KW'(NODES - 1)) begin
                        k_q     <= k_q + KW'(1);
                        state_q <= S_CALC;
                    end else if (it_q < IW'(ITER - 1)) begin
                        it_q <= it_q + IW'(1);
                        k_q  <= KW'(1);
`ifdef ROPE_PIN_EN
                        state_q  <= S_PIN;
                        fix_en_q <= NODES'(1);
                        x_fix_q  <= anchor_x;
                        y_fix_q  <= anchor_y;
`else
                        state_q  <= S_CALC;
`endif
                    end else begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign verlet_state     = verlet_q;
    assign fix_en           = fix_en_q;
    assign x_fix_constraint = x_fix_q;
    assign y_fix_constraint = y_fix_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign clamp_cnt        = clamp_cnt_q;
endmodule

// File: tb/tb_rope_solver_ctrl.sv
// tb/tb_rope_solver_ctrl.sv - randomized frame bench for rope_solver_ctrl against a chain relaxation model
module tb_rope_solver_ctrl;
    localparam int          NODES = 8;
    localparam int          ITER  = 4;
    localparam logic [31:0] REST  = 32'h00A00000;
    localparam int          R     = 32'h00A00000;
`ifdef ROPE_PIN_EN
    localparam bit PIN = 1'b1;
`else
    localparam bit PIN = 1'b0;
`endif
    localparam int PASS_CYC = PIN ? 2*NODES - 1 : 2*(NODES - 1);
    localparam int LAT      = 3 + ITER*PASS_CYC;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 start = 1'b0;
    logic [31:0]          anchor_x = '0;
    logic [31:0]          anchor_y = '0;
    logic [32*NODES-1:0]  x_pos_all;
    logic [32*NODES-1:0]  y_pos_all;
    logic                 verlet_state;
    logic [NODES-1:0]     fix_en;
    logic [31:0]          x_fix_constraint;
    logic [31:0]          y_fix_constraint;
    logic                 busy;
    logic                 done;
    logic [15:0]          clamp_cnt;

    logic [31:0] node_x [NODES];
    logic [31:0] node_y [NODES];
    logic [31:0] init_x [NODES];
    logic [31:0] init_y [NODES];
    logic        load_nodes = 1'b0;

    int          checks = 0;
    int          failures = 0;
    int          q_cyc [$];
    int          q_node [$];
    logic [31:0] q_x [$];
    logic [31:0] q_y [$];
    int          exp_clamps;

    always #5 clk = ~clk;

    rope_solver_ctrl #(.NODES(NODES), .ITER(ITER), .REST(REST)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .anchor_x         (anchor_x),
        .anchor_y         (anchor_y),
        .x_pos_all        (x_pos_all),
        .y_pos_all        (y_pos_all),
        .verlet_state     (verlet_state),
        .fix_en           (fix_en),
        .x_fix_constraint (x_fix_constraint),
        .y_fix_constraint (y_fix_constraint),
        .busy             (busy),
        .done             (done),
        .clamp_cnt        (clamp_cnt)
    );

    // Node models: hold position, latch the shared fix bus when selected.
    always_comb begin
        for (int i = 0; i < NODES; i++) begin
            x_pos_all[32*i +: 32] = node_x[i];
            y_pos_all[32*i +: 32] = node_y[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NODES; i++) begin
            if (load_nodes) begin
                node_x[i] <= init_x[i];
                node_y[i] <= init_y[i];
            end else if (fix_en[i]) begin
                node_x[i] <= x_fix_constraint;
                node_y[i] <= y_fix_constraint;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] relax(input logic [31:0] prev, input logic [31:0] cur,
                                          output bit hit);
        longint a, b, d, r;
        a = longint'($signed(prev));
        b = longint'($signed(cur));
        d = b - a;
        hit = 1'b1;
        if (d > longint'(REST))       r = a + longint'(REST);
        else if (d < -longint'(REST)) r = a - longint'(REST);
        else begin
            r = b;
            hit = 1'b0;
        end
        return r[31:0];
    endfunction

    function automatic int rnd_delta(input int span);
        return int'($urandom_range(0, 2*span)) - span;
    endfunction

    task automatic build_expect();
        logic [31:0] mx [NODES];
        logic [31:0] my [NODES];
        bit hx, hy;
        int base;
        q_cyc.delete(); q_node.delete(); q_x.delete(); q_y.delete();
        exp_clamps = 0;
        mx = init_x;
        my = init_y;
        for (int p = 0; p < ITER; p++) begin
            base = 3 + p*PASS_CYC;
            if (PIN) begin
                mx[0] = anchor_x;
                my[0] = anchor_y;
                q_cyc.push_back(base); q_node.push_back(0);
                q_x.push_back(anchor_x); q_y.push_back(anchor_y);
            end
            for (int k = 1; k < NODES; k++) begin
                mx[k] = relax(mx[k-1], mx[k], hx);
                my[k] = relax(my[k-1], my[k], hy);
                if (hx || hy) exp_clamps++;
                q_cyc.push_back(base + 2*k - (PIN ? 0 : 1));
                q_node.push_back(k);
                q_x.push_back(mx[k]); q_y.push_back(my[k]);
            end
        end
    endtask

    // mode 0: links within REST, 1: wide random, 2: x overflow pair, 3: exact/just-over REST steps
    task automatic gen(input int mode);
        int span, d;
        span = (mode == 0) ? R : 2*R;
        init_x[0] = $urandom;
        init_y[0] = $urandom;
        for (int i = 1; i < NODES; i++) begin
            if (mode == 3) begin
                d = R + int'($urandom_range(0, 1));
                init_x[i] = init_x[i-1] + 32'(($urandom_range(0, 1) == 1) ? d : -d);
                d = R + int'($urandom_range(0, 1));
                init_y[i] = init_y[i-1] + 32'(($urandom_range(0, 1) == 1) ? d : -d);
            end else begin
                init_x[i] = init_x[i-1] + 32'(rnd_delta(span));
                init_y[i] = init_y[i-1] + 32'(rnd_delta(span));
            end
        end
        anchor_x = init_x[0];
        anchor_y = init_y[0];
        if (mode == 1) begin
            anchor_x = init_x[0] + 32'(rnd_delta(span));
            anchor_y = init_y[0] + 32'(rnd_delta(span));
        end
        if (mode == 2) begin
            init_x[0] = 32'h7FF00000;
            anchor_x  = 32'h7FF00000;
            init_x[1] = 32'h80000000;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_verlet"}, 32'(verlet_state), 32'd0);
        check_eq({tag, "_fix_en"}, 32'(fix_en), 32'd0);
        check_eq({tag, "_xfix"}, x_fix_constraint, 32'd0);
        check_eq({tag, "_yfix"}, y_fix_constraint, 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_clamp"}, 32'(clamp_cnt), 32'd0);
    endtask

    task automatic run_frame(input int mode, input int poke_start, input int rst_cycle);
        gen(mode);
        build_expect();
        @(negedge clk) load_nodes = 1'b1;
        @(negedge clk) load_nodes = 1'b0;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 1; c <= LAT + 2; c++) begin
            if (c > 1) @(negedge clk);
            check_eq("verlet", 32'(verlet_state), 32'(c == 1));
            check_eq("busy", 32'(busy), 32'(c <= LAT));
            check_eq("done", 32'(done), 32'(c == LAT));
            if (q_cyc.size() > 0 && q_cyc[0] == c) begin
                check_eq("fix_en", 32'(fix_en), 32'd1 << q_node[0]);
                check_eq("x_fix", x_fix_constraint, q_x[0]);
                check_eq("y_fix", y_fix_constraint, q_y[0]);
                void'(q_cyc.pop_front()); void'(q_node.pop_front());
                void'(q_x.pop_front()); void'(q_y.pop_front());
            end else begin
                check_eq("fix_idle", 32'(fix_en), 32'd0);
            end
            if (c == LAT) check_eq("clamp_cnt", 32'(clamp_cnt), 32'(exp_clamps));
            start = (c == poke_start);
            if (c == rst_cycle) begin
                #2 reset = 1'b0;
                #1 check_idle_outputs("midreset");
                @(negedge clk) reset = 1'b1;
                for (int j = 0; j < LAT + 2; j++) begin
                    @(negedge clk);
                    check_eq("after_rst_done", 32'(done), 32'd0);
                    check_eq("after_rst_busy", 32'(busy), 32'd0);
                end
                return;
            end
        end
        check_eq("writes_left", 32'(q_cyc.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle_outputs("reset");
        end
        start = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("post_rst_busy", 32'(busy), 32'd0);
            check_eq("post_rst_verlet", 32'(verlet_state), 32'd0);
        end
        run_frame(0, 0, 0);
        run_frame(1, 10, 0);
        run_frame(2, 0, 0);
        run_frame(3, 0, 0);
        run_frame(1, 0, 20);
        run_frame(0, 5, 0);
        for (int n = 0; n < 4; n++) run_frame(int'($urandom_range(0, 3)), 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
